// File: rtl/pipeline_ctrl_if.sv
// Hazard-controller bundle: pipeline-side status in, stage enables/flushes,
// forward selects and performance counters out.
interface pipeline_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             ex_RegWrite;
    logic             ex_MemToReg;
    logic [4:0]       ex_WriteRegNo;
    logic             mem_RegWrite;
    logic [4:0]       mem_WriteRegNo;
    logic             ex_redirect;
    logic             wb_halt;
    logic             go;
    logic             pc_en;
    logic             if2id_en;
    logic             id2ex_en;
    logic             ex2mem_en;
    logic             mem2wb_en;
    logic             if2id_flush;
    logic             id2ex_flush;
    logic [1:0]       R1Forward;
    logic [1:0]       R2Forward;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_RegWrite, ex_MemToReg, ex_WriteRegNo,
        output mem_RegWrite, mem_WriteRegNo, ex_redirect, wb_halt, go,
        input  pc_en, if2id_en, id2ex_en, ex2mem_en, mem2wb_en,
        input  if2id_flush, id2ex_flush, R1Forward, R2Forward,
        input  halted, stall_cnt, flush_cnt, cycle_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_RegWrite, ex_MemToReg, ex_WriteRegNo,
        input  mem_RegWrite, mem_WriteRegNo, ex_redirect, wb_halt, go,
        output pc_en, if2id_en, id2ex_en, ex2mem_en, mem2wb_en,
        output if2id_flush, id2ex_flush, R1Forward, R2Forward,
        output halted, stall_cnt, flush_cnt, cycle_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard controller: load-use stall, redirect flush,
// operand forwarding selects, ecall halt/resume FSM and perf counters.
module pipeline_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input logic            clk,
    input logic            rst,
    pipeline_ctrl_if.slave bus
);
    typedef enum logic {RUN, HALT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             lu, rd, run;
    logic             pc_en, if2id_en, id2ex_en, ex2mem_en, mem2wb_en;
    logic             if2id_flush, id2ex_flush;
    logic [1:0]       r1_fwd, r2_fwd;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       ex_rw,
        input logic       ex_m2r,
        input logic [4:0] ex_rd,
        input logic       mem_rw,
        input logic [4:0] mem_rd
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (ex_rw && ex_rd != '0 && ex_rd == rs && !ex_m2r)
            sel = 2'b01;
        else if (mem_rw && mem_rd != '0 && mem_rd == rs)
            sel = 2'b10;
        return sel;
    endfunction

    always_comb begin
        state_d     = state_q;
        cycle_d     = cycle_q;
        stall_d     = stall_q;
        flush_d     = flush_q;
        pc_en       = 1'b1;
        if2id_en    = 1'b1;
        id2ex_en    = 1'b1;
        ex2mem_en   = 1'b1;
        mem2wb_en   = 1'b1;
        if2id_flush = 1'b0;
        id2ex_flush = 1'b0;

        run = (state_q == RUN);
        rd  = run && bus.ex_redirect;
        lu  = run && bus.ex_RegWrite && bus.ex_MemToReg && (bus.ex_WriteRegNo != '0) &&
              ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_WriteRegNo) ||
               (bus.id_use_rs2 && bus.id_rs2 == bus.ex_WriteRegNo));

        case (state_q)
            RUN:  if (bus.wb_halt) state_d = HALT;
            HALT: if (bus.go)      state_d = RUN;
            default: state_d = RUN;
        endcase

        if (run) begin
            cycle_d = cycle_q + 1'b1;
            if (rd)
                flush_d = flush_q + 1'b1;
            else if (lu)
                stall_d = stall_q + 1'b1;
        end

        // Reset dominates so downstream stage registers clear on any edge during reset.
        if (!rst) begin
            {pc_en, if2id_en, id2ex_en, ex2mem_en, mem2wb_en} = '0;
            if2id_flush = 1'b1;
            id2ex_flush = 1'b1;
        end else if (!run) begin
            {pc_en, if2id_en, id2ex_en, ex2mem_en, mem2wb_en} = '0;
        end else if (rd) begin
            if2id_flush = 1'b1;
            id2ex_flush = 1'b1;
        end else if (lu) begin
            pc_en       = 1'b0;
            if2id_en    = 1'b0;
            id2ex_flush = 1'b1;
        end

        r1_fwd = fwd_sel(bus.id_rs1, bus.ex_RegWrite, bus.ex_MemToReg, bus.ex_WriteRegNo,
                         bus.mem_RegWrite, bus.mem_WriteRegNo);
        r2_fwd = fwd_sel(bus.id_rs2, bus.ex_RegWrite, bus.ex_MemToReg, bus.ex_WriteRegNo,
                         bus.mem_RegWrite, bus.mem_WriteRegNo);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            cycle_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            cycle_q <= cycle_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign bus.pc_en       = pc_en;
    assign bus.if2id_en    = if2id_en;
    assign bus.id2ex_en    = id2ex_en;
    assign bus.ex2mem_en   = ex2mem_en;
    assign bus.mem2wb_en   = mem2wb_en;
    assign bus.if2id_flush = if2id_flush;
    assign bus.id2ex_flush = id2ex_flush;
    assign bus.R1Forward   = r1_fwd;
    assign bus.R2Forward   = r2_fwd;
    assign bus.halted      = (state_q == HALT);
    assign bus.stall_cnt   = stall_q;
    assign bus.flush_cnt   = flush_q;
    assign bus.cycle_cnt   = cycle_q;
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the five-stage pipeline. It drives the enable and flush (synchronous clear) inputs of the PC register and the IF2ID, ID2EX, EX2MEM and MEM2WB pipeline registers. It computes the R1Forward/R2Forward selects that ID2EX latches. It also runs the ecall halt/resume state machine and keeps stall/flush performance counters.

## Interface
- `CNT_W`, default 32: width of the performance counters.
- `clk` input 1: pipeline clock; all state updates on the rising edge.
- `rst` input 1: asynchronous reset, active-low.
- `id_rs1`, `id_rs2` input 5 each: source register numbers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2` input 1 each: the ID instruction actually reads that source.
- `ex_RegWrite`, `ex_MemToReg` input 1 each: control bits of the instruction in EX.
- `ex_WriteRegNo` input 5: destination register of the instruction in EX.
- `mem_RegWrite` input 1; `mem_WriteRegNo` input 5: control and destination of the instruction in MEM.
- `ex_redirect` input 1: taken BEQ/BNE/BLTU, or JAL/JALR, resolved in EX.
- `wb_halt` input 1: an ecall with halt code is in WB this cycle.
- `go` input 1: resume pulse from the board/debug logic.
- `pc_en`, `if2id_en`, `id2ex_en`, `ex2mem_en`, `mem2wb_en` output 1 each: stage register enables.
- `if2id_flush`, `id2ex_flush` output 1 each: synchronous clears for IF2ID and ID2EX, valid for the next edge.
- `R1Forward`, `R2Forward` output 2 each:
  - 00: register file value.
  - 01: EX2MEM ALU result.
  - 10: MEM2WB write-back value.
- `halted` output 1: the FSM is in HALT.
- `stall_cnt`, `flush_cnt`, `cycle_cnt` output CNT_W each: performance counters.

## Operation
- FSM has two states, RUN and HALT. Reset state is RUN.
- RUN → HALT on `wb_halt`. The halting ecall still commits, because the MEM2WB enable is 1 on that edge.
- HALT → RUN on `go`. `go` is ignored in RUN. `wb_halt` is ignored in HALT.
- In HALT, every `*_en` output and every flush output is 0, so the whole pipeline freezes.
- Load-use hazard `lu` is asserted when all of the following hold:
  - FSM is in RUN.
  - `ex_RegWrite` and `ex_MemToReg` are 1.
  - `ex_WriteRegNo` is not 0.
  - `(id_use_rs1 && id_rs1 == ex_WriteRegNo)` or `(id_use_rs2 && id_rs2 == ex_WriteRegNo)`.
- Redirect `rd` = RUN && `ex_redirect`.
- Outputs in RUN, in priority order:
  - When `rd` is set: all enables 1, `if2id_flush` = 1, `id2ex_flush` = 1. Redirect overrides `lu`, because the stalled instruction is wrong-path.
  - When only `lu` is set: `pc_en` = 0, `if2id_en` = 0, `id2ex_flush` = 1; the ex2mem and mem2wb enables stay 1. This holds IF/ID and inserts one bubble into EX.
  - Otherwise: all enables 1, both flushes 0.
- Forwarding, computed in ID for use when the instruction reaches EX. R1 is shown; R2 is identical with rs2.
  - 01 when `ex_RegWrite` && `ex_WriteRegNo` != 0 && `ex_WriteRegNo` == `id_rs1` && !`ex_MemToReg`.
  - Else 10 when `mem_RegWrite` && `mem_WriteRegNo` != 0 && `mem_WriteRegNo` == `id_rs1`.
  - Else 00.
  - EX has priority over MEM. A producer in WB needs no forward, because the register file writes before it reads.
  - After a load-use bubble the load sits in MEM, so the select resolves to 10.
- Counters:
  - `cycle_cnt` +1 every cycle in RUN.
  - `stall_cnt` +1 on each cycle with `lu` && !`rd`.
  - `flush_cnt` +1 on each cycle with `rd`.
  - All counters wrap modulo 2^CNT_W and freeze in HALT.

## Timing
- All enable, flush and forward outputs are combinational from FSM state and current inputs; there is no latency.
- FSM and counters are registered on the rising edge of `clk`.
- While `rst` is low:
  - FSM = RUN, all counters = 0, `halted` = 0.
  - All `*_en` are forced to 0 and both flushes are forced to 1, so downstream registers clear on any edge during reset.
- Release is asynchronous; the first edge after `rst` rises behaves as RUN.
- `halted` rises on the edge that samples `wb_halt`. All enables are 0 from that cycle onward.
- `go` in HALT: `halted` drops on the next edge, and enables return in the following cycle.
- `go` and `wb_halt` asserted together in RUN: go to HALT.
- `lu` lasts exactly one cycle per hazard. After the bubble, EX holds a non-load, so no extra stall is generated.

## Test plan
- Load-use: `lw x5` in EX (`ex_MemToReg` = 1, `ex_WriteRegNo` = 5), `add x6,x5,x1` in ID → one cycle of `pc_en` = 0, `if2id_en` = 0, `id2ex_flush` = 1; next cycle R1Forward = 10; `stall_cnt` = 1.
- ALU forward: EX writes x7 (non-load), ID reads rs2 = 7 → R2Forward = 01, no stall. The same write to x0 → 00.
- Double hazard: EX and MEM both write x3, ID reads x3 → R1Forward = 01.
- Redirect with `lu` in the same cycle → both flushes = 1, `pc_en` = 1, `flush_cnt` +1, `stall_cnt` unchanged.
- Halt: pulse `wb_halt` → `halted` = 1 and all enables 0 for 10 cycles, with counters frozen; pulse `go` → RUN and `cycle_cnt` resumes.
- Assert `rst` low while in HALT with counters nonzero → immediate `halted` = 0, counters 0, flushes 1; release → normal RUN.
